cpu_trace_buf: RTL

Synthesisable, parametrised instruction-trace capture buffer for the 8-bit CPU. On each sample strobe (CPU in ST_E1 with register-select idle) it records the instruction register plus all user registers into a circular RAM, and stops on a trigger under a selectable mode. It then streams the captured entries out, oldest first, over a valid/ready port. It sits beside the CPU in the DUT top and replaces per-cycle bench printing with on-chip capture.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/cpu_trace_ram.sv | 30 +++
 rtl/cpu_trace_buf.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit CPU slice: trace-buffer modes and states.
// The trace buffer imports these so the bench and the DUT top agree on encodings.
package cpu_pkg;

  typedef enum logic [1:0] {
    TM_WRAP = 2'd0,
    TM_FILL = 2'd1,
    TM_TRIG = 2'd2,
    TM_RSVD = 2'd3
  } trace_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_POST = 3'd2,
    ST_HOLD = 3'd3,
    ST_DUMP = 3'd4
  } trace_state_e;

  // The reserved encoding behaves exactly like WRAP.
  function automatic trace_mode_e trace_mode_norm(input logic [1:0] mode);
    return (mode == TM_RSVD) ? TM_WRAP : trace_mode_e'(mode);
  endfunction

endpackage

// File: rtl/cpu_trace_ram.sv
// Simple dual-port trace RAM: synchronous write, registered read.
// Only the read register is reset, so readout data is a clean zero after reset.
module cpu_trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 40
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it can map onto block RAM; stale contents
  // are never observable because readout only covers entries written this session.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/cpu_trace_buf.sv
// Instruction-trace capture buffer: records IR plus user registers per sample into a
// circular RAM, stops on a mode-dependent trigger, then streams entries oldest first.
module cpu_trace_buf
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int NUM_USR = 4,
  parameter int DEPTH   = 16
) (
  input  logic                        iclk,
  input  logic                        irst_n,
  input  logic                        iarm,
  input  logic [1:0]                  imode,
  input  logic [$clog2(DEPTH):0]      ipost_cnt,
  input  logic                        icapture,
  input  logic                        itrig,
  input  logic [DATA_W-1:0]           iir,
  input  logic [NUM_USR*DATA_W-1:0]   iusr,
  input  logic                        idump,
  output logic [DATA_W-1:0]           oir,
  output logic [NUM_USR*DATA_W-1:0]   ousr,
  output logic                        ovalid,
  input  logic                        iready,
  output logic [$clog2(DEPTH):0]      ocount,
  output logic                        ooverflow,
  output logic [2:0]                  ostate
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_W * (NUM_USR + 1);
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  trace_state_e  state_q, state_d;
  trace_mode_e   mode_q;
  logic [CW-1:0] post_tgt_q, post_cnt_q, count_q, left_q;
  logic [AW-1:0] wptr_q, rptr_q;
  logic          overflow_q, valid_q;
  logic          arm, capture, dump_start, ram_re, handshake, post_done;
  logic [EW-1:0] ram_rdata;

  // Arming is refused only while a readout is in flight; arming also wins over
  // any same-cycle capture, trigger or dump request.
  assign arm        = iarm && (state_q != ST_DUMP);
  assign capture    = icapture && !arm && (state_q == ST_RUN || state_q == ST_POST);
  assign dump_start = idump && !arm && (state_q == ST_HOLD) && (count_q != '0);
  assign ram_re     = (state_q == ST_DUMP) && !valid_q;
  assign handshake  = valid_q && iready;
  assign post_done  = capture && (state_q == ST_POST) && (post_cnt_q + CNT_ONE == post_tgt_q);

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (arm) state_d = ST_RUN;
      ST_RUN: begin
        if (arm) begin
          state_d = ST_RUN;
        end else if (itrig) begin
          if (mode_q == TM_TRIG) state_d = (post_tgt_q == '0) ? ST_HOLD : ST_POST;
          else                   state_d = ST_HOLD;
        end else if (capture && mode_q == TM_FILL && count_q == FULL - CNT_ONE) begin
          state_d = ST_HOLD;
        end
      end
      ST_POST: begin
        if (arm)            state_d = ST_RUN;
        else if (post_done) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (arm)        state_d = ST_RUN;
        else if (idump) state_d = (count_q == '0) ? ST_IDLE : ST_DUMP;
      end
      ST_DUMP: if (handshake && left_q == CNT_ONE) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours regardless of block ordering.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Session bookkeeping: write pointer, fill count, overflow and post-trigger count.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      mode_q     <= TM_WRAP;
      post_tgt_q <= '0;
      post_cnt_q <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (arm) begin
      mode_q     <= trace_mode_norm(imode);
      post_tgt_q <= ipost_cnt;
      post_cnt_q <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (capture) begin
      wptr_q <= wptr_q + PTR_ONE;
      if (count_q == FULL) overflow_q <= 1'b1;
      else                 count_q    <= count_q + CNT_ONE;
      if (state_q == ST_POST) post_cnt_q <= post_cnt_q + CNT_ONE;
    end
  end

  // Readout: fetch one entry, hold it until accepted, then idle a cycle while the
  // next address is presented to the registered RAM read port.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      rptr_q  <= '0;
      left_q  <= '0;
      valid_q <= 1'b0;
    end else if (dump_start) begin
      rptr_q  <= wptr_q - count_q[AW-1:0];
      left_q  <= count_q;
      valid_q <= 1'b0;
    end else if (state_q == ST_DUMP) begin
      if (ram_re) begin
        valid_q <= 1'b1;
      end else if (handshake) begin
        valid_q <= 1'b0;
        rptr_q  <= rptr_q + PTR_ONE;
        left_q  <= left_q - CNT_ONE;
      end
    end
  end

  cpu_trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk   (iclk),
    .rst_n (irst_n),
    .we    (capture),
    .waddr (wptr_q),
    .wdata ({iusr, iir}),
    .re    (ram_re),
    .raddr (rptr_q),
    .rdata (ram_rdata)
  );

  assign oir       = ram_rdata[DATA_W-1:0];
  assign ousr      = ram_rdata[EW-1:DATA_W];
  assign ovalid    = valid_q;
  assign ocount    = count_q;
  assign ooverflow = overflow_q;
  assign ostate    = state_q;

endmodule
